axil_mem_arbiter: RTL and testbench

//  Shares one AXI4-Lite memory slave between two masters: M0 = instruction fetch (read-only),
//  M1 = load/store unit (read + write). One transaction owns the slave at a time; round-robin

---
 rtl/axil_arb_pkg.sv | 11 +
 rtl/rr_pick2.sv | 13 +
 rtl/axil_mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_axil_mem_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_arb_pkg.sv
// axil_arb_pkg: shared state/owner types and response constants for the AXI4-Lite memory arbiter
package axil_arb_pkg;

    typedef enum logic [2:0] {IDLE, RD, WR, ERR_R, ERR_W} arb_state_t;
    typedef enum logic {OWN_M0, OWN_M1} owner_t;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [31:0] ERR_RDATA   = 32'hDEADBEEF;

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin picker; on a tie the master not served last wins
module rr_pick2
    import axil_arb_pkg::*;
(
    input  logic   req0,
    input  logic   req1,
    input  owner_t last,
    output owner_t grant
);

    assign grant = (req1 && (!req0 || last == OWN_M0)) ? OWN_M1 : OWN_M0;

endmodule

// File: rtl/axil_mem_arbiter.sv
// axil_mem_arbiter: shares one AXI4-Lite memory slave between fetch (M0, read-only) and LSU (M1)
module axil_mem_arbiter
    import axil_arb_pkg::*;
#(
    parameter int AXI_AWIDTH  = 32,
    parameter int AXI_DWIDTH  = 32,
    parameter int TIMEOUT_CYC = 16
)(
    input  logic                    AXI_ACLK,
    input  logic                    AXI_ARESETN,
    input  logic [AXI_AWIDTH-1:0]   M0_AXI_ARADDR,
    input  logic                    M0_AXI_ARVALID,
    output logic                    M0_AXI_ARREADY,
    output logic [AXI_DWIDTH-1:0]   M0_AXI_RDATA,
    output logic [1:0]              M0_AXI_RRESP,
    output logic                    M0_AXI_RVALID,
    input  logic                    M0_AXI_RREADY,
    input  logic [AXI_AWIDTH-1:0]   M1_AXI_AWADDR,
    input  logic                    M1_AXI_AWVALID,
    output logic                    M1_AXI_AWREADY,
    input  logic [AXI_DWIDTH-1:0]   M1_AXI_WDATA,
    input  logic [AXI_DWIDTH/8-1:0] M1_AXI_WSTRB,
    input  logic                    M1_AXI_WVALID,
    output logic                    M1_AXI_WREADY,
    output logic [1:0]              M1_AXI_BRESP,
    output logic                    M1_AXI_BVALID,
    input  logic                    M1_AXI_BREADY,
    input  logic [AXI_AWIDTH-1:0]   M1_AXI_ARADDR,
    input  logic                    M1_AXI_ARVALID,
    output logic                    M1_AXI_ARREADY,
    output logic [AXI_DWIDTH-1:0]   M1_AXI_RDATA,
    output logic [1:0]              M1_AXI_RRESP,
    output logic                    M1_AXI_RVALID,
    input  logic                    M1_AXI_RREADY,
    output logic [AXI_AWIDTH-1:0]   S_AXI_AWADDR,
    output logic                    S_AXI_AWVALID,
    input  logic                    S_AXI_AWREADY,
    output logic [AXI_DWIDTH-1:0]   S_AXI_WDATA,
    output logic [AXI_DWIDTH/8-1:0] S_AXI_WSTRB,
    output logic                    S_AXI_WVALID,
    input  logic                    S_AXI_WREADY,
    input  logic [1:0]              S_AXI_BRESP,
    input  logic                    S_AXI_BVALID,
    output logic                    S_AXI_BREADY,
    output logic [AXI_AWIDTH-1:0]   S_AXI_ARADDR,
    output logic                    S_AXI_ARVALID,
    input  logic                    S_AXI_ARREADY,
    input  logic [AXI_DWIDTH-1:0]   S_AXI_RDATA,
    input  logic [1:0]              S_AXI_RRESP,
    input  logic                    S_AXI_RVALID,
    output logic                    S_AXI_RREADY
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    arb_state_t    state, state_nx;
    owner_t        owner, last, pick;
    logic [TW-1:0] timer;
    logic          rq0, rq1r, rq1w, any_rq, rd_done, wr_done, tmo, first, err_ack;
    logic          g_rd0, g_rd1, g_wr, e_r0, e_r1, e_w;

    assign rq0    = M0_AXI_ARVALID;
    assign rq1r   = M1_AXI_ARVALID;
    assign rq1w   = M1_AXI_AWVALID & M1_AXI_WVALID;
    assign any_rq = rq0 | rq1r | rq1w;

    rr_pick2 u_pick (
        .req0  (rq0),
        .req1  (rq1r | rq1w),
        .last  (last),
        .grant (pick)
    );

    assign rd_done = S_AXI_RVALID & S_AXI_RREADY;
    assign wr_done = S_AXI_BVALID & S_AXI_BREADY;
    assign tmo     = timer == TW'(TIMEOUT_CYC - 1);
    // timer restarts on every state change, so it also marks the first cycle of an error state
    assign first   = timer == '0;
    assign err_ack = owner == OWN_M0 ? M0_AXI_RREADY : M1_AXI_RREADY;

    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            state <= IDLE;
            owner <= OWN_M0;
            last  <= OWN_M1;
            timer <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && any_rq) begin
                owner <= pick;
                last  <= pick;
            end
            timer <= (state_nx != state) ? '0 : timer + TW'(timer != TW'(TIMEOUT_CYC));
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any_rq) state_nx = (pick == OWN_M1 && rq1w) ? WR : RD;
            RD:      state_nx = rd_done ? IDLE : tmo ? ERR_R : RD;
            WR:      state_nx = wr_done ? IDLE : tmo ? ERR_W : WR;
            ERR_R:   if (err_ack) state_nx = IDLE;
            ERR_W:   if (M1_AXI_BREADY) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign g_rd0 = state == RD && owner == OWN_M0;
    assign g_rd1 = state == RD && owner == OWN_M1;
    assign g_wr  = state == WR;
    assign e_r0  = state == ERR_R && owner == OWN_M0;
    assign e_r1  = state == ERR_R && owner == OWN_M1;
    assign e_w   = state == ERR_W;

    assign S_AXI_ARADDR  = g_rd0 ? M0_AXI_ARADDR : g_rd1 ? M1_AXI_ARADDR : '0;
    assign S_AXI_ARVALID = g_rd0 ? M0_AXI_ARVALID : g_rd1 & M1_AXI_ARVALID;
    assign S_AXI_RREADY  = g_rd0 ? M0_AXI_RREADY : g_rd1 & M1_AXI_RREADY;
    assign S_AXI_AWADDR  = g_wr ? M1_AXI_AWADDR : '0;
    assign S_AXI_AWVALID = g_wr & M1_AXI_AWVALID;
    assign S_AXI_WDATA   = g_wr ? M1_AXI_WDATA : '0;
    assign S_AXI_WSTRB   = g_wr ? M1_AXI_WSTRB : '0;
    assign S_AXI_WVALID  = g_wr & M1_AXI_WVALID;
    assign S_AXI_BREADY  = g_wr & M1_AXI_BREADY;

    assign M0_AXI_ARREADY = g_rd0 ? S_AXI_ARREADY : e_r0 & first;
    assign M0_AXI_RVALID  = g_rd0 ? S_AXI_RVALID : e_r0;
    assign M0_AXI_RDATA   = g_rd0 ? S_AXI_RDATA : e_r0 ? AXI_DWIDTH'(ERR_RDATA) : '0;
    assign M0_AXI_RRESP   = g_rd0 ? S_AXI_RRESP : e_r0 ? RESP_SLVERR : RESP_OKAY;

    assign M1_AXI_ARREADY = g_rd1 ? S_AXI_ARREADY : e_r1 & first;
    assign M1_AXI_RVALID  = g_rd1 ? S_AXI_RVALID : e_r1;
    assign M1_AXI_RDATA   = g_rd1 ? S_AXI_RDATA : e_r1 ? AXI_DWIDTH'(ERR_RDATA) : '0;
    assign M1_AXI_RRESP   = g_rd1 ? S_AXI_RRESP : e_r1 ? RESP_SLVERR : RESP_OKAY;

    assign M1_AXI_AWREADY = g_wr ? S_AXI_AWREADY : e_w & first;
    assign M1_AXI_WREADY  = g_wr ? S_AXI_WREADY : e_w & first;
    assign M1_AXI_BVALID  = g_wr ? S_AXI_BVALID : e_w;
    assign M1_AXI_BRESP   = g_wr ? S_AXI_BRESP : e_w ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_axil_mem_arbiter.sv
// tb_axil_mem_arbiter: randomized bench with a one-cycle memory slave stub and a word-array reference model
module tb_axil_mem_arbiter;

    localparam int TO = 16;

    logic        AXI_ACLK, AXI_ARESETN;
    logic [31:0] M0_AXI_ARADDR, M0_AXI_RDATA;
    logic        M0_AXI_ARVALID, M0_AXI_ARREADY, M0_AXI_RVALID, M0_AXI_RREADY;
    logic [1:0]  M0_AXI_RRESP;
    logic [31:0] M1_AXI_AWADDR, M1_AXI_WDATA, M1_AXI_ARADDR, M1_AXI_RDATA;
    logic [3:0]  M1_AXI_WSTRB;
    logic        M1_AXI_AWVALID, M1_AXI_AWREADY, M1_AXI_WVALID, M1_AXI_WREADY;
    logic        M1_AXI_BVALID, M1_AXI_BREADY, M1_AXI_ARVALID, M1_AXI_ARREADY;
    logic        M1_AXI_RVALID, M1_AXI_RREADY;
    logic [1:0]  M1_AXI_BRESP, M1_AXI_RRESP;
    logic [31:0] S_AXI_AWADDR, S_AXI_WDATA, S_AXI_ARADDR, S_AXI_RDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
    logic        S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
    logic        S_AXI_RVALID, S_AXI_RREADY;
    logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;

    int          checks = 0, errors = 0, cyc = 0, m_last;
    int          order[$];
    logic        silent;
    logic [31:0] mem [256];
    logic [31:0] model_mem [256];
    logic        any_out;

    axil_mem_arbiter dut (
        .AXI_ACLK(AXI_ACLK), .AXI_ARESETN(AXI_ARESETN),
        .M0_AXI_ARADDR(M0_AXI_ARADDR), .M0_AXI_ARVALID(M0_AXI_ARVALID), .M0_AXI_ARREADY(M0_AXI_ARREADY),
        .M0_AXI_RDATA(M0_AXI_RDATA), .M0_AXI_RRESP(M0_AXI_RRESP), .M0_AXI_RVALID(M0_AXI_RVALID),
        .M0_AXI_RREADY(M0_AXI_RREADY),
        .M1_AXI_AWADDR(M1_AXI_AWADDR), .M1_AXI_AWVALID(M1_AXI_AWVALID), .M1_AXI_AWREADY(M1_AXI_AWREADY),
        .M1_AXI_WDATA(M1_AXI_WDATA), .M1_AXI_WSTRB(M1_AXI_WSTRB), .M1_AXI_WVALID(M1_AXI_WVALID),
        .M1_AXI_WREADY(M1_AXI_WREADY), .M1_AXI_BRESP(M1_AXI_BRESP), .M1_AXI_BVALID(M1_AXI_BVALID),
        .M1_AXI_BREADY(M1_AXI_BREADY),
        .M1_AXI_ARADDR(M1_AXI_ARADDR), .M1_AXI_ARVALID(M1_AXI_ARVALID), .M1_AXI_ARREADY(M1_AXI_ARREADY),
        .M1_AXI_RDATA(M1_AXI_RDATA), .M1_AXI_RRESP(M1_AXI_RRESP), .M1_AXI_RVALID(M1_AXI_RVALID),
        .M1_AXI_RREADY(M1_AXI_RREADY),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
        .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
        .S_AXI_RREADY(S_AXI_RREADY)
    );

    initial AXI_ACLK = 0;
    always #5 AXI_ACLK = ~AXI_ACLK;
    always @(posedge AXI_ACLK) cyc <= cyc + 1;

    assign any_out = |{S_AXI_ARVALID, S_AXI_AWVALID, S_AXI_WVALID, S_AXI_RREADY, S_AXI_BREADY,
                       S_AXI_ARADDR, S_AXI_AWADDR, S_AXI_WDATA, S_AXI_WSTRB,
                       M0_AXI_ARREADY, M0_AXI_RVALID, M0_AXI_RDATA, M0_AXI_RRESP,
                       M1_AXI_AWREADY, M1_AXI_WREADY, M1_AXI_BVALID, M1_AXI_BRESP,
                       M1_AXI_ARREADY, M1_AXI_RVALID, M1_AXI_RDATA, M1_AXI_RRESP};

    // slave stub: accepts when idle, answers one cycle later; silent mode never accepts
    assign S_AXI_ARREADY = !S_AXI_RVALID && !silent;
    assign S_AXI_AWREADY = !S_AXI_BVALID && !silent;
    assign S_AXI_WREADY  = S_AXI_AWREADY;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_BRESP   = 2'b00;

    always @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            S_AXI_RVALID <= 0;
            S_AXI_BVALID <= 0;
            S_AXI_RDATA  <= 0;
            for (int i = 0; i < 256; i++) mem[i] <= (i == 4) ? 32'h13 : 32'h0;
        end else begin
            if (S_AXI_RVALID && S_AXI_RREADY) S_AXI_RVALID <= 0;
            else if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                S_AXI_RVALID <= 1;
                S_AXI_RDATA  <= mem[S_AXI_ARADDR[9:2]];
            end
            if (S_AXI_BVALID && S_AXI_BREADY) S_AXI_BVALID <= 0;
            else if (S_AXI_AWVALID && S_AXI_WVALID && S_AXI_AWREADY) begin
                S_AXI_BVALID <= 1;
                for (int b = 0; b < 4; b++)
                    if (S_AXI_WSTRB[b]) mem[S_AXI_AWADDR[9:2]][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
            end
        end
    end

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++)
            if (s[b]) model_mem[a[9:2]][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic apply_reset();
        AXI_ARESETN = 0;
        silent = 0;
        {M0_AXI_ARADDR, M0_AXI_ARVALID, M0_AXI_RREADY} = '0;
        {M1_AXI_AWADDR, M1_AXI_AWVALID, M1_AXI_WDATA, M1_AXI_WSTRB, M1_AXI_WVALID, M1_AXI_BREADY} = '0;
        {M1_AXI_ARADDR, M1_AXI_ARVALID, M1_AXI_RREADY} = '0;
        repeat (3) @(posedge AXI_ACLK);
        #1 AXI_ARESETN = 1;
        for (int i = 0; i < 256; i++) model_mem[i] = (i == 4) ? 32'h13 : 32'h0;
        m_last = 1;
    endtask

    // called and returns at 1 time unit after a rising edge
    task automatic do_read(input int m, input logic [31:0] a, output logic [31:0] d, output logic [1:0] r,
                           output int t0, output int tar, output int tr);
        logic arr, rv;
        t0 = cyc; tar = -1; tr = -1; d = 'x; r = 'x;
        if (m == 0) begin M0_AXI_ARADDR = a; M0_AXI_ARVALID = 1; M0_AXI_RREADY = 1; end
        else        begin M1_AXI_ARADDR = a; M1_AXI_ARVALID = 1; M1_AXI_RREADY = 1; end
        for (int i = 0; i < 64 && tr < 0; i++) begin
            @(negedge AXI_ACLK);
            arr = m ? M1_AXI_ARREADY : M0_AXI_ARREADY;
            rv  = m ? M1_AXI_RVALID : M0_AXI_RVALID;
            if (arr && tar < 0) tar = cyc;
            if (rv) begin
                checks++;
                if (tar < 0) begin
                    errors++;
                    $display("FAIL r_before_ar m%0d: R beat at cycle %0d, required address accepted first", m, cyc);
                end
                d = m ? M1_AXI_RDATA : M0_AXI_RDATA;
                r = m ? M1_AXI_RRESP : M0_AXI_RRESP;
                tr = cyc;
            end
            @(posedge AXI_ACLK); #1;
            if (tar >= 0) begin if (m == 0) M0_AXI_ARVALID = 0; else M1_AXI_ARVALID = 0; end
        end
        if (m == 0) begin M0_AXI_ARVALID = 0; M0_AXI_RREADY = 0; end
        else        begin M1_AXI_ARVALID = 0; M1_AXI_RREADY = 0; end
        checks++;
        if (tr < 0) begin errors++; $display("FAIL read_timeout m%0d addr %h: no R beat, required one", m, a); end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] r, output int t0, output int tb);
        bit aw_done = 0;
        t0 = cyc; tb = -1; r = 'x;
        M1_AXI_AWADDR = a; M1_AXI_WDATA = d; M1_AXI_WSTRB = s;
        M1_AXI_AWVALID = 1; M1_AXI_WVALID = 1; M1_AXI_BREADY = 1;
        for (int i = 0; i < 64 && tb < 0; i++) begin
            @(negedge AXI_ACLK);
            if (M1_AXI_AWREADY && M1_AXI_WREADY) aw_done = 1;
            if (M1_AXI_BVALID) begin r = M1_AXI_BRESP; tb = cyc; end
            @(posedge AXI_ACLK); #1;
            if (aw_done) begin M1_AXI_AWVALID = 0; M1_AXI_WVALID = 0; end
        end
        M1_AXI_AWVALID = 0; M1_AXI_WVALID = 0; M1_AXI_BREADY = 0;
        checks++;
        if (tb < 0) begin errors++; $display("FAIL write_timeout addr %h: no B beat, required one", a); end
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge AXI_ACLK);
        checks++;
        if (any_out !== 1'b0) begin errors++; $display("FAIL reset_outputs: OR of outputs %b, required 0", any_out); end
        @(posedge AXI_ACLK); #1;
    endtask

    task automatic test_single_read();
        logic [31:0] d; logic [1:0] r; int t0, ta, tr;
        do_read(0, 32'h10, d, r, t0, ta, tr);
        checks += 4;
        if (d !== 32'h13) begin errors++; $display("FAIL single_rdata: got %h, required 00000013", d); end
        if (r !== 2'b00) begin errors++; $display("FAIL single_rresp: got %b, required 00", r); end
        if (ta - t0 != 1) begin errors++; $display("FAIL single_grant_lat: got %0d, required 1", ta - t0); end
        if (tr - t0 != 2) begin errors++; $display("FAIL single_rvalid_lat: got %0d, required 2", tr - t0); end
        m_last = 0;
    endtask

    task automatic test_write_read();
        logic [31:0] d; logic [1:0] r, br; int t0, tb, ta, tr;
        model_write(32'h20, 32'hA5A5A5A5, 4'b0011);
        do_write(32'h20, 32'hA5A5A5A5, 4'b0011, br, t0, tb);
        checks += 2;
        if (br !== 2'b00) begin errors++; $display("FAIL wr_bresp: got %b, required 00", br); end
        if (tb - t0 != 2) begin errors++; $display("FAIL wr_bvalid_lat: got %0d, required 2", tb - t0); end
        do_read(1, 32'h20, d, r, t0, ta, tr);
        checks += 3;
        if (d !== 32'h0000A5A5) begin errors++; $display("FAIL wr_readback: got %h, required 0000a5a5", d); end
        if (d !== model_mem[8]) begin errors++; $display("FAIL wr_readback_model: got %h, required %h", d, model_mem[8]); end
        if (r !== 2'b00) begin errors++; $display("FAIL wr_readback_rresp: got %b, required 00", r); end
        m_last = 1;
    endtask

    task automatic test_write_priority();
        logic [31:0] a, wd, d; logic [3:0] s; logic [1:0] br, r; int wt0, wtb, rt0, rta, rtr;
        for (int k = 0; k < 4; k++) begin
            a  = {22'd0, 8'($urandom_range(255, 0)), 2'b00};
            wd = $urandom;
            s  = 4'($urandom_range(15, 1));
            model_write(a, wd, s);
            fork
                do_write(a, wd, s, br, wt0, wtb);
                do_read(1, a, d, r, rt0, rta, rtr);
            join
            checks += 3;
            if (br !== 2'b00) begin errors++; $display("FAIL prio_bresp[%0d]: got %b, required 00", k, br); end
            if (rta != wtb + 2) begin errors++; $display("FAIL prio_order[%0d]: read grant cycle %0d, required %0d", k, rta, wtb + 2); end
            if (d !== model_mem[a[9:2]]) begin errors++; $display("FAIL prio_rdata[%0d]: got %h, required %h", k, d, model_mem[a[9:2]]); end
        end
        m_last = 1;
    endtask

    task automatic rr_master(input int m);
        logic [31:0] a, d; logic [1:0] r; int t0, ta, tr;
        for (int k = 0; k < 5; k++) begin
            a = {22'd0, 8'($urandom_range(255, 0)), 2'b00};
            do_read(m, a, d, r, t0, ta, tr);
            checks++;
            if (d !== model_mem[a[9:2]] || r !== 2'b00)
                begin errors++; $display("FAIL rr_rdata m%0d: got %h/%b, required %h/00", m, d, r, model_mem[a[9:2]]); end
            order.push_back(m);
        end
    endtask

    task automatic test_round_robin();
        int first_m;
        first_m = (m_last == 1) ? 0 : 1;
        order.delete();
        fork
            rr_master(0);
            rr_master(1);
        join
        checks++;
        if (order.size() != 10) begin errors++; $display("FAIL rr_count: got %0d, required 10", order.size()); end
        for (int i = 0; i < order.size(); i++) begin
            checks++;
            if (order[i] != (first_m + i) % 2)
                begin errors++; $display("FAIL rr_order[%0d]: got M%0d, required M%0d", i, order[i], (first_m + i) % 2); end
        end
        if (order.size() > 0) m_last = order[order.size() - 1];
    endtask

    task automatic test_timeout();
        logic [31:0] a, d; logic [1:0] r; int t0, ta, tr;
        silent = 1;
        do_read(0, 32'h40, d, r, t0, ta, tr);
        checks += 4;
        if (r !== 2'b10) begin errors++; $display("FAIL tmo_rresp: got %b, required 10", r); end
        if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL tmo_rdata: got %h, required deadbeef", d); end
        if (tr - t0 != TO + 1) begin errors++; $display("FAIL tmo_lat: got %0d, required %0d", tr - t0, TO + 1); end
        if (ta != tr) begin errors++; $display("FAIL tmo_arready: pulse cycle %0d, required %0d", ta, tr); end
        silent = 0;
        m_last = 0;
        a = {22'd0, 8'($urandom_range(255, 0)), 2'b00};
        do_read(1, a, d, r, t0, ta, tr);
        checks += 2;
        if (d !== model_mem[a[9:2]] || r !== 2'b00)
            begin errors++; $display("FAIL tmo_next_rdata: got %h/%b, required %h/00", d, r, model_mem[a[9:2]]); end
        if (tr - t0 != 2) begin errors++; $display("FAIL tmo_next_lat: got %0d, required 2", tr - t0); end
        m_last = 1;
    endtask

    task automatic test_reset_mid_grant();
        logic [31:0] d; logic [1:0] r; int t0, ta, tr;
        silent = 1;
        M0_AXI_ARADDR = 32'h10; M0_AXI_ARVALID = 1; M0_AXI_RREADY = 1;
        repeat (3) @(posedge AXI_ACLK);
        checks++;
        #1 if (S_AXI_ARVALID !== 1'b1) begin errors++; $display("FAIL mid_grant_active: S_ARVALID %b, required 1", S_AXI_ARVALID); end
        #2 AXI_ARESETN = 0;
        #1 checks++;
        if (any_out !== 1'b0) begin errors++; $display("FAIL mid_reset_outputs: OR of outputs %b, required 0", any_out); end
        M0_AXI_ARVALID = 0; M0_AXI_RREADY = 0; silent = 0;
        @(posedge AXI_ACLK); #1 AXI_ARESETN = 1;
        for (int i = 0; i < 256; i++) model_mem[i] = (i == 4) ? 32'h13 : 32'h0;
        m_last = 1;
        @(posedge AXI_ACLK); #1;
        do_read(0, 32'h10, d, r, t0, ta, tr);
        checks += 2;
        if (d !== model_mem[4] || r !== 2'b00) begin errors++; $display("FAIL post_reset_rdata: got %h/%b, required %h/00", d, r, model_mem[4]); end
        if (tr - t0 != 2) begin errors++; $display("FAIL post_reset_lat: got %0d, required 2", tr - t0); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_read();
        test_write_read();
        test_write_priority();
        test_round_robin();
        test_timeout();
        test_reset_mid_grant();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
